// File: rtl/pio_pkg.sv
// Shared PIO definitions: bus action codes, loader sizing and loader state encoding.
package pio_pkg;

  localparam int NUM_SM     = 4;
  localparam int IMEM_DEPTH = 32;
  localparam int TBL_AW     = 6;

  localparam logic [3:0] ACT_NOP     = 4'd0;
  localparam logic [3:0] ACT_INSTR   = 4'd1;
  localparam logic [3:0] ACT_WRAP    = 4'd2;
  localparam logic [3:0] ACT_PINS    = 4'd5;
  localparam logic [3:0] ACT_EN      = 4'd6;
  localparam logic [3:0] ACT_DIV     = 4'd7;
  localparam logic [3:0] ACT_SIDESET = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PROG_RD = 3'd1,
    ST_PROG_WR = 3'd2,
    ST_CFG_RD  = 3'd3,
    ST_CFG_WR  = 3'd4,
    ST_FIN     = 3'd5
  } ld_state_e;

endpackage

// File: rtl/pio_bus_mux.sv
// Registered 2:1 selector for the pio bus: loader fields unless the host is granted.
module pio_bus_mux
  import pio_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_sel,
  input  logic [3:0]  ld_action,
  input  logic [31:0] ld_din,
  input  logic [4:0]  ld_index,
  input  logic [1:0]  ld_mindex,
  input  logic [3:0]  host_action,
  input  logic [31:0] host_din,
  input  logic [4:0]  host_index,
  input  logic [1:0]  host_mindex,
  output logic [3:0]  action,
  output logic [31:0] din,
  output logic [4:0]  index,
  output logic [1:0]  mindex,
  output logic        host_ack
);

  logic [3:0]  action_r;
  logic [31:0] din_r;
  logic [4:0]  index_r;
  logic [1:0]  mindex_r;
  logic        host_ack_r;

  // Bus output register; the grant pulse lines up with the host fields it carries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      action_r   <= ACT_NOP;
      din_r      <= 32'd0;
      index_r    <= 5'd0;
      mindex_r   <= 2'd0;
      host_ack_r <= 1'b0;
    end else if (host_sel) begin
      action_r   <= host_action;
      din_r      <= host_din;
      index_r    <= host_index;
      mindex_r   <= host_mindex;
      host_ack_r <= 1'b1;
    end else begin
      action_r   <= ld_action;
      din_r      <= ld_din;
      index_r    <= ld_index;
      mindex_r   <= ld_mindex;
      host_ack_r <= 1'b0;
    end
  end

  assign action   = action_r;
  assign din      = din_r;
  assign index    = index_r;
  assign mindex   = mindex_r;
  assign host_ack = host_ack_r;

endmodule

// File: rtl/pio_loader.sv
// PIO bring-up loader: streams program words and per-machine config writes from a
// table memory onto the pio bus, and lends that bus to a host port when idle.
module pio_loader
  import pio_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [5:0]        prog_len,
  input  logic [5:0]        cfg_len,
  input  logic [NUM_SM-1:0] sm_mask,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [35:0]       tbl_data,
  input  logic              host_req,
  input  logic [3:0]        host_action,
  input  logic [31:0]       host_din,
  input  logic [1:0]        host_mindex,
  input  logic [4:0]        host_index,
  output logic              host_ack,
  output logic [3:0]        action,
  output logic [31:0]       din,
  output logic [4:0]        index,
  output logic [1:0]        mindex,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  ld_state_e         state_r, state_s;
  logic [5:0]        pc_r, pc_s, ci_r, ci_s;
  logic [5:0]        plen_r, plen_s, clen_r, clen_s, elen_r, elen_s;
  logic [NUM_SM-1:0] mask_r, mask_s, rem_r, rem_s;
  logic [TBL_AW-1:0] tbl_addr_r, tbl_addr_s;
  logic              busy_r, busy_s, done_r, done_s, aborted_r, aborted_s;
  logic [5:0]        eff_len_s;
  logic [1:0]        low_sm_s;
  logic              entry_end_s, host_sel_s;
  logic [3:0]        ld_action_s;
  logic [31:0]       ld_din_s;
  logic [4:0]        ld_index_s;
  logic [1:0]        ld_mindex_s;

  assign eff_len_s = (prog_len > 6'(IMEM_DEPTH)) ? 6'(IMEM_DEPTH) : prog_len;

  // Lowest machine still owed the current config entry.
  always_comb begin
    low_sm_s = 2'd0;
    for (int i = NUM_SM - 1; i >= 0; i--) begin
      if (rem_r[i]) begin
        low_sm_s = 2'(i);
      end else begin
        low_sm_s = low_sm_s;
      end
    end
  end

  // Next-state and loader bus fields; next-state lookahead keeps tbl_addr one cycle ahead of data.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    ci_s        = ci_r;
    plen_s      = plen_r;
    clen_s      = clen_r;
    elen_s      = elen_r;
    mask_s      = mask_r;
    rem_s       = rem_r;
    tbl_addr_s  = tbl_addr_r;
    ld_action_s = ACT_NOP;
    ld_din_s    = 32'd0;
    ld_index_s  = 5'd0;
    ld_mindex_s = 2'd0;
    done_s      = 1'b0;
    aborted_s   = 1'b0;
    host_sel_s  = 1'b0;
    entry_end_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          plen_s = prog_len;
          clen_s = cfg_len;
          elen_s = eff_len_s;
          mask_s = sm_mask;
          pc_s   = 6'd0;
          ci_s   = 6'd0;
          if (eff_len_s != 6'd0) begin
            state_s    = ST_PROG_RD;
            tbl_addr_s = {TBL_AW{1'b0}};
          end else if (cfg_len != 6'd0) begin
            state_s    = ST_CFG_RD;
            tbl_addr_s = TBL_AW'(prog_len);
          end else begin
            state_s = ST_FIN;
          end
        end else if (host_req && !host_ack) begin
          host_sel_s = 1'b1;
        end else begin
          host_sel_s = 1'b0;
        end
      end
      ST_PROG_RD: state_s = ST_PROG_WR;
      ST_PROG_WR: begin
        ld_action_s = ACT_INSTR;
        ld_din_s    = {16'd0, tbl_data[15:0]};
        ld_index_s  = pc_r[4:0];
        pc_s        = pc_r + 6'd1;
        if (pc_s != elen_r) begin
          state_s    = ST_PROG_RD;
          tbl_addr_s = TBL_AW'(pc_s);
        end else if (clen_r != 6'd0) begin
          state_s    = ST_CFG_RD;
          tbl_addr_s = TBL_AW'(plen_r);
        end else begin
          state_s = ST_FIN;
        end
      end
      ST_CFG_RD: begin
        state_s = ST_CFG_WR;
        rem_s   = mask_r;
      end
      ST_CFG_WR: begin
        if ((tbl_data[35:32] == ACT_NOP) || (rem_r == {NUM_SM{1'b0}})) begin
          entry_end_s = 1'b1;
        end else begin
          ld_action_s = tbl_data[35:32];
          ld_din_s    = tbl_data[31:0];
          ld_mindex_s = low_sm_s;
          rem_s       = rem_r & (rem_r - {{(NUM_SM-1){1'b0}}, 1'b1});
          entry_end_s = (rem_s == {NUM_SM{1'b0}});
        end
        if (!entry_end_s) begin
          state_s = ST_CFG_WR;
        end else begin
          ci_s = ci_r + 6'd1;
          if (ci_s == clen_r) begin
            state_s = ST_FIN;
          end else begin
            state_s    = ST_CFG_RD;
            tbl_addr_s = TBL_AW'(plen_r + ci_s);
          end
        end
      end
      ST_FIN: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: state_s = ST_IDLE;
    endcase
    // Abort squashes whatever write this cycle would have issued.
    if (abort && (state_r inside {ST_PROG_RD, ST_PROG_WR, ST_CFG_RD, ST_CFG_WR})) begin
      state_s     = ST_IDLE;
      ld_action_s = ACT_NOP;
      aborted_s   = 1'b1;
    end else begin
      aborted_s = aborted_s;
    end
    busy_s = (state_s inside {ST_PROG_RD, ST_PROG_WR, ST_CFG_RD, ST_CFG_WR});
  end

  // Sequencer state, captured parameters and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      pc_r       <= 6'd0;
      ci_r       <= 6'd0;
      plen_r     <= 6'd0;
      clen_r     <= 6'd0;
      elen_r     <= 6'd0;
      mask_r     <= {NUM_SM{1'b0}};
      rem_r      <= {NUM_SM{1'b0}};
      tbl_addr_r <= {TBL_AW{1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      aborted_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      ci_r       <= ci_s;
      plen_r     <= plen_s;
      clen_r     <= clen_s;
      elen_r     <= elen_s;
      mask_r     <= mask_s;
      rem_r      <= rem_s;
      tbl_addr_r <= tbl_addr_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      aborted_r  <= aborted_s;
    end
  end

  pio_bus_mux u_bus_mux (
    .clk         (clk),
    .reset_n     (reset_n),
    .host_sel    (host_sel_s),
    .ld_action   (ld_action_s),
    .ld_din      (ld_din_s),
    .ld_index    (ld_index_s),
    .ld_mindex   (ld_mindex_s),
    .host_action (host_action),
    .host_din    (host_din),
    .host_index  (host_index),
    .host_mindex (host_mindex),
    .action      (action),
    .din         (din),
    .index       (index),
    .mindex      (mindex),
    .host_ack    (host_ack)
  );

  assign tbl_addr = tbl_addr_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign aborted  = aborted_r;

endmodule

// File: tb/tb_pio_loader.sv
// Directed bench for pio_loader: program load, config fan-out, clamping, host arbitration,
// abort and asynchronous reset, each against hand-computed pulses and latencies.
module tb_pio_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [5:0]  prog_len = 6'd0;
  logic [5:0]  cfg_len = 6'd0;
  logic [3:0]  sm_mask = 4'd0;
  logic [5:0]  tbl_addr;
  logic [35:0] tbl_data = 36'd0;
  logic        host_req = 1'b0;
  logic [3:0]  host_action = 4'd0;
  logic [31:0] host_din = 32'd0;
  logic [1:0]  host_mindex = 2'd0;
  logic [4:0]  host_index = 5'd0;
  logic        host_ack;
  logic [3:0]  action;
  logic [31:0] din;
  logic [4:0]  index;
  logic [1:0]  mindex;
  logic        busy, done, aborted;

  pio_loader dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .prog_len(prog_len), .cfg_len(cfg_len), .sm_mask(sm_mask),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .host_req(host_req), .host_action(host_action), .host_din(host_din),
    .host_mindex(host_mindex), .host_index(host_index), .host_ack(host_ack),
    .action(action), .din(din), .index(index), .mindex(mindex),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  logic [35:0] mem [64];
  always @(posedge clk) tbl_data <= mem[tbl_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write log: every nonzero action seen on the bus, plus pulse counters.
  logic [3:0]  la [256];
  logic [31:0] ld [256];
  logic [4:0]  li [256];
  logic [1:0]  lm [256];
  int nlog = 0, done_cnt = 0, done_cyc = 0, abort_cnt = 0, ack_cnt = 0;
  always @(negedge clk) begin
    if (action != 4'd0 && nlog < 256) begin
      la[nlog] <= action; ld[nlog] <= din; li[nlog] <= index; lm[nlog] <= mindex;
      nlog <= nlog + 1;
    end
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; end
    if (aborted) abort_cnt <= abort_cnt + 1;
    if (host_ack) ack_cnt <= ack_cnt + 1;
  end

  int vectors = 0, miscompares = 0;
  int start_cyc = 0;

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 36'd0;
  endtask

  task automatic do_start();
    tick(); start = 1'b1; start_cyc = cyc;
    tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int bd, input int budget);
    int k = 0;
    while (done_cnt == bd && k < budget) begin tick(); k++; end
    vectors++;
    if (done_cnt == bd) begin
      miscompares++; $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(); tick();
    vectors++; if (action !== 4'd0)   begin miscompares++; $display("FAIL reset_action: got %0h want 0", action); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
    vectors++; if (tbl_addr !== 6'd0) begin miscompares++; $display("FAIL reset_addr: got %0d want 0", tbl_addr); end
    vectors++; if ({done, aborted, host_ack} !== 3'b000) begin miscompares++; $display("FAIL reset_pulses: got %b want 000", {done, aborted, host_ack}); end
    vectors++; if (din !== 32'd0)     begin miscompares++; $display("FAIL reset_din: got %h want 0", din); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic check_prog4(input int base, input string tag);
    logic [15:0] w [4];
    w[0] = 16'hE081; w[1] = 16'hE101; w[2] = 16'hE000; w[3] = 16'h0001;
    vectors++;
    if (nlog - base !== 4) begin miscompares++; $display("FAIL %s_count: got %0d want 4", tag, nlog - base); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({la[base+k], li[base+k], lm[base+k], ld[base+k]} !== {4'd1, 5'(k), 2'd0, 16'd0, w[k]}) begin
        miscompares++;
        $display("FAIL %s_w%0d: got act %0h idx %0d sm %0d din %h want act 1 idx %0d sm 0 din %h",
                 tag, k, la[base+k], li[base+k], lm[base+k], ld[base+k], k, {16'd0, w[k]});
      end
    end
    vectors++;
    if (done_cyc - start_cyc !== 10) begin miscompares++; $display("FAIL %s_latency: got %0d want 10", tag, done_cyc - start_cyc); end
  endtask

  task automatic load_prog4();
    clear_mem();
    mem[0] = 36'h3_ABCD_E081; mem[1] = 36'h5_1234_E101;
    mem[2] = 36'hF_FFFF_E000; mem[3] = 36'h0_0000_0001;
    prog_len = 6'd4; cfg_len = 6'd0; sm_mask = 4'b1111;
  endtask

  task automatic test_prog();
    int base, bd;
    load_prog4();
    base = nlog; bd = done_cnt;
    do_start();
    wait_done(bd, 40);
    check_prog4(base, "prog");
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL prog_busy_after: got %0b want 0", busy); end
  endtask

  task automatic test_cfg();
    int base, bd;
    logic [3:0]  ea [4];
    logic [31:0] ed [4];
    logic [1:0]  em [4];
    ea[0] = 4'd2; ed[0] = 32'd3; em[0] = 2'd0;
    ea[1] = 4'd2; ed[1] = 32'd3; em[1] = 2'd2;
    ea[2] = 4'd6; ed[2] = 32'd1; em[2] = 2'd0;
    ea[3] = 4'd6; ed[3] = 32'd1; em[3] = 2'd2;
    clear_mem();
    mem[0] = 36'h2_0000_0003; mem[1] = 36'h6_0000_0001;
    prog_len = 6'd0; cfg_len = 6'd2; sm_mask = 4'b0101;
    base = nlog; bd = done_cnt;
    do_start();
    sm_mask = 4'b1111;
    wait_done(bd, 40);
    vectors++;
    if (nlog - base !== 4) begin miscompares++; $display("FAIL cfg_count: got %0d want 4", nlog - base); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if ({la[base+k], lm[base+k], ld[base+k]} !== {ea[k], em[k], ed[k]}) begin
        miscompares++;
        $display("FAIL cfg_w%0d: got act %0h sm %0d din %h want act %0h sm %0d din %h",
                 k, la[base+k], lm[base+k], ld[base+k], ea[k], em[k], ed[k]);
      end
    end
    vectors++;
    if (done_cyc - start_cyc !== 8) begin miscompares++; $display("FAIL cfg_latency: got %0d want 8", done_cyc - start_cyc); end
  endtask

  task automatic test_clamp();
    int base, bd;
    clear_mem();
    for (int i = 0; i < 40; i++) mem[i] = {20'd0, 16'h0100 + 16'(i)};
    mem[40] = 36'h7_0000_0055;
    prog_len = 6'd40; cfg_len = 6'd1; sm_mask = 4'b1000;
    base = nlog; bd = done_cnt;
    do_start();
    wait_done(bd, 120);
    vectors++;
    if (nlog - base !== 33) begin miscompares++; $display("FAIL clamp_count: got %0d want 33", nlog - base); end
    for (int k = 0; k < 32; k++) begin
      vectors++;
      if ({la[base+k], li[base+k], ld[base+k]} !== {4'd1, 5'(k), 16'd0, 16'h0100 + 16'(k)}) begin
        miscompares++;
        $display("FAIL clamp_w%0d: got act %0h idx %0d din %h", k, la[base+k], li[base+k], ld[base+k]);
      end
    end
    vectors++;
    if ({la[base+32], lm[base+32], ld[base+32]} !== {4'd7, 2'd3, 32'h55}) begin
      miscompares++;
      $display("FAIL clamp_cfg: got act %0h sm %0d din %h want act 7 sm 3 din 00000055",
               la[base+32], lm[base+32], ld[base+32]);
    end
    vectors++;
    if (done_cyc - start_cyc !== 68) begin miscompares++; $display("FAIL clamp_latency: got %0d want 68", done_cyc - start_cyc); end
  endtask

  task automatic test_host_busy();
    int bd, bk, ack_cyc, k;
    logic got;
    logic [3:0] ga; logic [31:0] gd; logic [1:0] gm; logic [4:0] gi;
    clear_mem();
    mem[0] = 36'h0_0000_E081; mem[1] = 36'h0_0000_E101;
    prog_len = 6'd2; cfg_len = 6'd0; sm_mask = 4'b0001;
    bd = done_cnt; bk = ack_cnt;
    do_start();
    host_action = 4'd7; host_din = 32'h280; host_mindex = 2'd1; host_index = 5'd3; host_req = 1'b1;
    got = 1'b0; k = 0; ack_cyc = 0;
    ga = 4'd0; gd = 32'd0; gm = 2'd0; gi = 5'd0;
    while (!got && k < 30) begin
      tick(); k++;
      if (host_ack) begin
        got = 1'b1; ack_cyc = cyc; ga = action; gd = din; gm = mindex; gi = index;
        host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    vectors++; if (!got) begin miscompares++; $display("FAIL host_grant: no host_ack within 30 cycles"); end
    vectors++; if (done_cnt !== bd + 1) begin miscompares++; $display("FAIL host_done_first: done count %0d want %0d", done_cnt - bd, 1); end
    vectors++; if (ack_cyc - start_cyc !== 7) begin miscompares++; $display("FAIL host_ack_cycle: got %0d want 7", ack_cyc - start_cyc); end
    vectors++;
    if ({ga, gd, gm, gi} !== {4'd7, 32'h280, 2'd1, 5'd3}) begin
      miscompares++; $display("FAIL host_fields: got act %0h din %h sm %0d idx %0d want 7 280 1 3", ga, gd, gm, gi);
    end
    tick(); tick(); tick();
    vectors++; if (ack_cnt - bk !== 1) begin miscompares++; $display("FAIL host_single: got %0d acks want 1", ack_cnt - bk); end
  endtask

  task automatic test_abort();
    int base, bd, ba;
    clear_mem();
    mem[0] = 36'h2_0000_0003; mem[1] = 36'h6_0000_0001;
    prog_len = 6'd0; cfg_len = 6'd2; sm_mask = 4'b0101;
    base = nlog; bd = done_cnt; ba = abort_cnt;
    do_start();
    tick(); tick();
    vectors++; if ({action, busy} !== {4'd2, 1'b1}) begin miscompares++; $display("FAIL abort_pre: got act %0h busy %0b want 2 1", action, busy); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if ({action, aborted, busy} !== {4'd0, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL abort_next: got act %0h aborted %0b busy %0b want 0 1 0", action, aborted, busy);
    end
    repeat (12) tick();
    vectors++; if (done_cnt !== bd) begin miscompares++; $display("FAIL abort_no_done: got %0d dones want 0", done_cnt - bd); end
    vectors++; if (abort_cnt - ba !== 1) begin miscompares++; $display("FAIL abort_pulse: got %0d want 1", abort_cnt - ba); end
    vectors++; if (nlog - base !== 1) begin miscompares++; $display("FAIL abort_writes: got %0d want 1", nlog - base); end
    abort = 1'b1;
    tick(); tick();
    abort = 1'b0;
    vectors++; if (abort_cnt - ba !== 1) begin miscompares++; $display("FAIL abort_idle: got %0d pulses want 1", abort_cnt - ba); end
  endtask

  task automatic test_reset_mid();
    int base, bd;
    load_prog4();
    do_start();
    repeat (4) tick();
    vectors++;
    if ({action, busy, tbl_addr} !== {4'd1, 1'b1, 6'd2}) begin
      miscompares++; $display("FAIL rst_mid_pre: got act %0h busy %0b addr %0d want 1 1 2", action, busy, tbl_addr);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({action, busy, tbl_addr} !== {4'd0, 1'b0, 6'd0}) begin
      miscompares++; $display("FAIL rst_mid_async: got act %0h busy %0b addr %0d want 0 0 0", action, busy, tbl_addr);
    end
    tick();
    reset_n = 1'b1;
    tick();
    base = nlog; bd = done_cnt;
    do_start();
    wait_done(bd, 40);
    check_prog4(base, "reload");
  endtask

  initial begin
    clear_mem();
    #1;
    test_reset();
    test_prog();
    test_cfg();
    test_clamp();
    test_host_busy();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
